// File: rtl/aes_pkg.sv
// Shared AES definitions: the S-box, byte/word helpers and the key-expansion state type.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic int nw(input int nr);
    return 4 * (nr + 1);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign word_o[8*g +: 8] = SBOX[word_i[8*g +: 8]];
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key expansion streaming w[0]..w[4*(NR+1)-1], one word per handshake.
// Define AES_KEYEXP_SCHED_EN to also collect the flat schedule on round_keys/sched_valid.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_LEN = 128,
  parameter int NR      = 10,
  parameter int NK      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KEY_LEN-1:0]      key,
  output logic [31:0]             w_data,
  output logic [5:0]              w_index,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    busy,
  output logic                    done,
  output logic [128*(NR+1)-1:0]   round_keys,
  output logic                    sched_valid,
  output state_e                  state_o
);

  localparam int NW = nw(NR);
  localparam int CW = $clog2(NK);

  // Handshake: a word transfers on a rising edge with w_valid && w_ready; while
  // w_valid && !w_ready, w_data/w_index hold and nothing internal advances.

  state_e              state_q, state_d;
  logic [NK-1:0][31:0] win_q, win_d;    // win[0] = w[i-NK] .. win[NK-1] = w[i-1]
  logic [31:0]         data_q, data_d;
  logic [5:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;    // (index of next word) mod NK
  logic [CW-1:0]       cnt_inc;
  logic [7:0]          rcon_q, rcon_d;
  logic                hs, step;
  logic [31:0]         sub_in, sub_out, temp, new_w;

  assign w_valid = (state_q == LOAD) || (state_q == EXPAND);
  assign hs      = w_valid && w_ready;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign w_data  = data_q;
  assign w_index = idx_q;
  assign state_o = state_q;
  assign cnt_inc = (cnt_q == CW'(NK - 1)) ? '0 : CW'(cnt_q + 1'b1);

  assign sub_in = (cnt_q == '0) ? rot_word(win_q[NK-1]) : win_q[NK-1];

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp = win_q[NK-1];
    if (cnt_q == '0) temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK > 6 && cnt_q == CW'(4)) temp = sub_out;
    new_w = win_q[0] ^ temp;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    step    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        for (int k = 0; k < NK; k++) win_d[k] = key[KEY_LEN-1-32*k -: 32];
        data_d  = key[KEY_LEN-1 -: 32];
        idx_d   = '0;
        cnt_d   = CW'(1);
        rcon_d  = 8'h01;
      end
      LOAD: if (hs) begin
        if (idx_q == 6'(NK - 1)) begin
          step    = 1'b1;
          state_d = EXPAND;
        end else begin
          data_d = win_q[cnt_q];
          idx_d  = idx_q + 6'd1;
          cnt_d  = cnt_inc;
        end
      end
      EXPAND: if (hs) begin
        if (idx_q == 6'(NW - 1)) state_d = DONE;
        else step = 1'b1;
      end
      DONE: state_d = IDLE;
    endcase
    // Word i is formed on the handshake of i-1 and the window slides by one.
    if (step) begin
      win_d  = {new_w, win_q[NK-1:1]};
      data_d = new_w;
      idx_d  = idx_q + 6'd1;
      cnt_d  = cnt_inc;
      if (cnt_q == '0) rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
    end
  end

`ifdef AES_KEYEXP_SCHED_EN
  logic [128*(NR+1)-1:0] rk_q;
  logic                  sv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q <= '0;
      sv_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) sv_q <= 1'b0;
      else if (state_q == EXPAND && hs && idx_q == 6'(NW - 1)) sv_q <= 1'b1;
      for (int k = 0; k < NW; k++) begin
        if (hs && idx_q == 6'(k)) rk_q[32*(NW-1-k) +: 32] <= data_q;
      end
    end
  end

  assign round_keys  = rk_q;
  assign sched_valid = sv_q;
`else
  assign round_keys  = '0;
  assign sched_valid = 1'b0;
`endif

endmodule
